// File: rtl/eth_tx_arb_pkg.sv
// rtl/eth_tx_arb_pkg.sv - shared types and helpers for the Ethernet TX frame arbiter
package eth_tx_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        XFER,
        ABORT,
        DRAIN,
        IFG
    } arb_state_t;

    localparam int lp_STAT_WIDTH = 16;

    function automatic int cnt_width(input int ifg_cycles, input int stall_timeout);
        int m;
        m = (ifg_cycles > stall_timeout) ? ifg_cycles : stall_timeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/eth_rr_arbiter.sv
// rtl/eth_rr_arbiter.sv - combinational round-robin picker: first request at or after the pointer
module eth_rr_arbiter #(
    parameter int P_NUM_REQ = 2
) (
    input  logic [P_NUM_REQ-1:0]         i_req,
    input  logic [$clog2(P_NUM_REQ)-1:0] i_ptr,
    output logic [P_NUM_REQ-1:0]         o_grant,
    output logic [$clog2(P_NUM_REQ)-1:0] o_index,
    output logic                         o_any
);

    localparam int lp_IW = $clog2(P_NUM_REQ);

    always_comb begin
        o_index = '0;
        o_any   = |i_req;
        // Scan from the farthest offset down so the nearest request wins.
        for (int off = P_NUM_REQ - 1; off >= 0; off--) begin
            if (i_req[(int'(i_ptr) + off) % P_NUM_REQ]) begin
                o_index = lp_IW'((int'(i_ptr) + off) % P_NUM_REQ);
            end
        end
        o_grant = o_any ? (P_NUM_REQ'(1) << o_index) : '0;
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - frame-level round-robin TX arbiter with IFG and stall abort
// Optional statistics counters enabled by ETH_TX_ARBITER_STATS_EN.
module eth_tx_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int P_NUM_REQ       = 2,
    parameter int P_DATA_WIDTH    = 8,
    parameter int P_IFG_CYCLES    = 12,
    parameter int P_STALL_TIMEOUT = 1024
) (
    input  logic                              i_clock,
    input  logic                              i_reset_n,
    input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_s_tdata,
    input  logic [P_NUM_REQ-1:0]              i_s_tvalid,
    input  logic [P_NUM_REQ-1:0]              i_s_tlast,
    output logic [P_NUM_REQ-1:0]              o_s_tready,
    output logic [P_DATA_WIDTH-1:0]           o_m_tdata,
    output logic                              o_m_tvalid,
    output logic                              o_m_tlast,
    output logic                              o_m_tuser,
    input  logic                              i_m_tready,
    output logic [P_NUM_REQ-1:0]              o_grant,
    output logic                              o_busy,
    output logic                              o_timeout
`ifdef ETH_TX_ARBITER_STATS_EN
    ,
    output logic [P_NUM_REQ*lp_STAT_WIDTH-1:0] o_frame_count,
    output logic [lp_STAT_WIDTH-1:0]           o_abort_count
`endif
);

    localparam int lp_CW = cnt_width(P_IFG_CYCLES, P_STALL_TIMEOUT);
    localparam int lp_IW = $clog2(P_NUM_REQ);

    arb_state_t              state;
    logic [lp_IW-1:0]        rr_ptr;
    logic [lp_IW-1:0]        gnt_idx;
    logic [lp_IW-1:0]        next_ptr;
    logic [lp_CW-1:0]        stall_cnt;
    logic [lp_CW-1:0]        ifg_cnt;
    logic [P_NUM_REQ-1:0]    arb_grant;
    logic [lp_IW-1:0]        arb_idx;
    logic                    arb_any;
    logic [P_DATA_WIDTH-1:0] g_data;
    logic                    g_valid;
    logic                    g_last;

    eth_rr_arbiter #(
        .P_NUM_REQ(P_NUM_REQ)
    ) u_rr_arbiter (
        .i_req  (i_s_tvalid),
        .i_ptr  (rr_ptr),
        .o_grant(arb_grant),
        .o_index(arb_idx),
        .o_any  (arb_any)
    );

    assign g_data   = i_s_tdata[int'(gnt_idx)*P_DATA_WIDTH +: P_DATA_WIDTH];
    assign g_valid  = i_s_tvalid[gnt_idx];
    assign g_last   = i_s_tlast[gnt_idx];
    assign next_ptr = (gnt_idx == lp_IW'(P_NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign o_busy   = (state != IDLE);

    always_comb begin
        o_m_tdata  = '0;
        o_m_tvalid = 1'b0;
        o_m_tlast  = 1'b0;
        o_m_tuser  = 1'b0;
        o_s_tready = '0;
        case (state)
            XFER: begin
                o_m_tdata           = g_data;
                o_m_tvalid          = g_valid;
                o_m_tlast           = g_last;
                o_s_tready[gnt_idx] = i_m_tready;
            end
            ABORT: begin
                o_m_tvalid = 1'b1;
                o_m_tlast  = 1'b1;
                o_m_tuser  = 1'b1;
            end
            DRAIN: o_s_tready[gnt_idx] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt_idx   <= '0;
            o_grant   <= '0;
            stall_cnt <= '0;
            ifg_cnt   <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        gnt_idx   <= arb_idx;
                        o_grant   <= arb_grant;
                        stall_cnt <= '0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    // MAC backpressure with data present is not a source stall.
                    if (g_valid && i_m_tready) begin
                        stall_cnt <= '0;
                        if (g_last) begin
                            rr_ptr  <= next_ptr;
                            o_grant <= '0;
                            ifg_cnt <= '0;
                            state   <= IFG;
                        end
                    end else if (!g_valid) begin
                        if (stall_cnt == lp_CW'(P_STALL_TIMEOUT - 1)) begin
                            stall_cnt <= '0;
                            state     <= ABORT;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
                end
                ABORT: begin
                    if (i_m_tready) begin
                        o_timeout <= 1'b1;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (g_valid && g_last) begin
                        rr_ptr  <= next_ptr;
                        o_grant <= '0;
                        ifg_cnt <= '0;
                        state   <= IFG;
                    end
                end
                IFG: begin
                    if (ifg_cnt == lp_CW'(P_IFG_CYCLES - 1)) begin
                        ifg_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        ifg_cnt <= ifg_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ETH_TX_ARBITER_STATS_EN
    logic [lp_STAT_WIDTH-1:0] frame_cnt [P_NUM_REQ];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < P_NUM_REQ; k++) begin
                frame_cnt[k] <= '0;
            end
            o_abort_count <= '0;
        end else begin
            if (state == XFER && g_valid && i_m_tready && g_last && frame_cnt[gnt_idx] != '1) begin
                frame_cnt[gnt_idx] <= frame_cnt[gnt_idx] + 1'b1;
            end
            if (o_timeout && o_abort_count != '1) begin
                o_abort_count <= o_abort_count + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < P_NUM_REQ; k++) begin : g_frame_count
        assign o_frame_count[k*lp_STAT_WIDTH +: lp_STAT_WIDTH] = frame_cnt[k];
    end
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb/tb_eth_tx_arbiter.sv - scoreboard bench for eth_tx_arbiter (optional ETH_TX_ARBITER_STATS_EN)
module tb_eth_tx_arbiter;

    localparam int N     = 3;
    localparam int DW    = 8;
    localparam int IFG   = 12;
    localparam int STALL = 1024;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tuser;
    logic            m_tready = 1'b0;
    logic [N-1:0]    grant;
    logic            busy;
    logic            timeout;
`ifdef ETH_TX_ARBITER_STATS_EN
    logic [N*16-1:0] frame_count;
    logic [15:0]     abort_count;
`endif

    logic [DW-1:0] drv_data  [N];
    logic          drv_valid [N];
    logic          drv_last  [N];

    beat_t exp_q [N][$];
    int    n_checks = 0;
    int    n_pass = 0;
    int    exp_frames [N];
    int    exp_aborts = 0;
    int    timeout_seen = 0;
    int    rdy_mode = 2;

    int         mon_ptr = 0;
    logic       mon_prev_idle = 1'b0;
    logic [N-1:0] mon_prev_req = '0;
    logic [N-1:0] mon_cur_grant = '0;
    int         mon_ifg_run = -1;

    always #5 clk = ~clk;

    always_comb begin
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        for (int k = 0; k < N; k++) begin
            s_tdata[k*DW +: DW] = drv_data[k];
            s_tvalid[k]         = drv_valid[k];
            s_tlast[k]          = drv_last[k];
        end
    end

    eth_tx_arbiter #(
        .P_NUM_REQ      (N),
        .P_DATA_WIDTH   (DW),
        .P_IFG_CYCLES   (IFG),
        .P_STALL_TIMEOUT(STALL)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_s_tdata (s_tdata),
        .i_s_tvalid(s_tvalid),
        .i_s_tlast (s_tlast),
        .o_s_tready(s_tready),
        .o_m_tdata (m_tdata),
        .o_m_tvalid(m_tvalid),
        .o_m_tlast (m_tlast),
        .o_m_tuser (m_tuser),
        .i_m_tready(m_tready),
        .o_grant   (grant),
        .o_busy    (busy),
        .o_timeout (timeout)
`ifdef ETH_TX_ARBITER_STATS_EN
        ,
        .o_frame_count(frame_count),
        .o_abort_count(abort_count)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [N-1:0] pick(input logic [N-1:0] req, input int p);
        for (int o = 0; o < N; o++) begin
            if (req[(p + o) % N]) return N'(1) << ((p + o) % N);
        end
        return '0;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic drive_beat(input int k, input logic [DW-1:0] d, input logic last);
        logic acc;
        drv_data[k]  = d;
        drv_last[k]  = last;
        drv_valid[k] = 1'b1;
        do begin
            @(negedge clk);
            acc = s_tready[k];
            @(posedge clk);
            #1;
        end while (!acc);
    endtask

    // Expected output per frame: all bytes, or the bytes before the stall followed by one abort beat.
    task automatic send_frame(input int k, input int len, input int abort_at, input bit gaps);
        logic [DW-1:0] d;
        beat_t         b;
        for (int i = 0; i < len; i++) begin
            d = DW'($urandom);
            if (abort_at < 0 || i < abort_at) begin
                b = '{data: d, last: (i == len - 1), user: 1'b0};
                exp_q[k].push_back(b);
            end else if (i == abort_at) begin
                b = '{data: '0, last: 1'b1, user: 1'b1};
                exp_q[k].push_back(b);
            end
            if (i == abort_at) begin
                drv_valid[k] = 1'b0;
                repeat (STALL + 40) @(posedge clk);
                #1;
            end else if (gaps && $urandom_range(0, 3) == 0) begin
                drv_valid[k] = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            drive_beat(k, d, (i == len - 1));
        end
        drv_valid[k] = 1'b0;
        drv_last[k]  = 1'b0;
        if (abort_at < 0) exp_frames[k]++;
        else exp_aborts++;
    endtask

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_tready = ($urandom_range(0, 3) != 0);
                1: m_tready = ~m_tready;
                default: m_tready = 1'b1;
            endcase
        end
    end

    initial begin : monitor
        beat_t got;
        beat_t want;
        int    owner;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_ptr = 0;
                mon_prev_idle = 1'b0;
                mon_cur_grant = '0;
                mon_ifg_run = -1;
                continue;
            end
            if (timeout) timeout_seen++;
            if (mon_prev_idle) check("rr_grant", 64'(grant), 64'(pick(mon_prev_req, mon_ptr)));
            if (mon_cur_grant != '0 && grant != mon_cur_grant) begin
                check("grant_hold", 64'(grant), 64'(0));
                mon_ptr = (onehot_idx(mon_cur_grant) + 1) % N;
                mon_ifg_run = 0;
            end
            if (mon_ifg_run >= 0) begin
                if (busy) mon_ifg_run++;
                else begin
                    check("ifg_len", 64'(mon_ifg_run), 64'(IFG));
                    mon_ifg_run = -1;
                end
            end
            if (m_tvalid && m_tready) begin
                check("beat_has_owner", 64'(grant != '0), 64'(1));
                owner = onehot_idx(grant);
                check("beat_expected", 64'(exp_q[owner].size() > 0), 64'(1));
                if (exp_q[owner].size() > 0) begin
                    want = exp_q[owner].pop_front();
                    got  = '{data: m_tdata, last: m_tlast, user: m_tuser};
                    check("beat", 64'(got), 64'(want));
                end
            end
            mon_cur_grant = grant;
            mon_prev_idle = !busy;
            mon_prev_req  = s_tvalid;
        end
    end

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        for (int k = 0; k < N; k++) begin
            drv_data[k]   = '0;
            drv_valid[k]  = 1'b0;
            drv_last[k]   = 1'b0;
            exp_frames[k] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_s_tready", 64'(s_tready), 64'(0));
        check("rst_m_out", 64'({m_tvalid, m_tlast, m_tuser, m_tdata}), 64'(0));
        check("rst_timeout", 64'(timeout), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        rdy_mode = 2;
        send_frame(0, 42, -1, 0);
        fork
            send_frame(0, 60, -1, 0);
            send_frame(1, 60, -1, 0);
        join
        rdy_mode = 1;
        send_frame(2, 74, -1, 0);

        rdy_mode = 0;
        fork
            begin
                for (int f = 0; f < 5; f++) send_frame(0, $urandom_range(1, 64), -1, 1);
            end
            begin
                for (int f = 0; f < 5; f++) begin
                    if (f == 2) send_frame(1, 30, 10, 1);
                    else send_frame(1, $urandom_range(1, 64), -1, 1);
                end
            end
            begin
                for (int f = 0; f < 5; f++) send_frame(2, $urandom_range(1, 64), -1, 1);
            end
        join
        repeat (IFG + 5) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) check("queue_drained", 64'(exp_q[k].size()), 64'(0));
        check("timeout_pulses", 64'(timeout_seen), 64'(exp_aborts));
`ifdef ETH_TX_ARBITER_STATS_EN
        for (int k = 0; k < N; k++) check("frame_count", 64'(frame_count[k*16 +: 16]), 64'(exp_frames[k]));
        check("abort_count", 64'(abort_count), 64'(exp_aborts));
`endif

        rdy_mode = 2;
        for (int i = 0; i < 30; i++) begin
            beat_t b;
            logic [DW-1:0] d;
            d = DW'($urandom);
            b = '{data: d, last: 1'b0, user: 1'b0};
            exp_q[0].push_back(b);
            drive_beat(0, d, 1'b0);
        end
        drv_data[0] = DW'($urandom);
        rst_n = 1'b0;
        #1;
        check("rst_mid_m_tvalid", 64'(m_tvalid), 64'(0));
        check("rst_mid_m_tdata", 64'(m_tdata), 64'(0));
        check("rst_mid_s_tready", 64'(s_tready), 64'(0));
        check("rst_mid_grant", 64'(grant), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        drv_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fork
            send_frame(1, 3, -1, 0);
            begin
                int waited;
                waited = 0;
                while (grant == '0 && waited < 10) begin
                    @(negedge clk);
                    waited++;
                end
                check("post_rst_grant", 64'(grant), 64'(3'b010));
            end
        join
        repeat (IFG + 5) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) check("final_drained", 64'(exp_q[k].size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
Frame-level round-robin arbiter that shares the single MII transmit MAC between independent reply generators (ARP responder, ICMP echo responder, spare).
- Sits between the requesters' byte streams and the MAC TX stream interface, in the PHY TX clock domain.
- Guarantees that frames are never interleaved and that the minimum inter-frame gap is honoured.
- Aborts frames whose source stalls mid-frame.

Parameters:
- P_NUM_REQ, 2, number of requesters (2..8).
- P_DATA_WIDTH, 8, stream data width in bits.
- P_IFG_CYCLES, 12, idle cycles forced after each frame (96 bit times at byte rate).
- P_STALL_TIMEOUT, 1024, consecutive granted-source starve cycles before abort.

Ports:
- i_clock  in  1  TX-domain clock.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_s_tdata  in  P_NUM_REQ*P_DATA_WIDTH  requester data, requester k at slice k.
- i_s_tvalid  in  P_NUM_REQ  requester valid.
- i_s_tlast  in  P_NUM_REQ  requester last byte of frame.
- o_s_tready  out  P_NUM_REQ  requester ready.
- o_m_tdata  out  P_DATA_WIDTH  data to MAC.
- o_m_tvalid  out  1  valid to MAC.
- o_m_tlast  out  1  last to MAC.
- o_m_tuser  out  1  frame-abort flag, valid with tlast.
- i_m_tready  in  1  MAC ready.
- o_grant  out  P_NUM_REQ  one-hot current owner, all-zero when no owner.
- o_busy  out  1  high in any state other than IDLE.
- o_timeout  out  1  one-cycle pulse on abort.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; RR pointer = 0; counters = 0.
  - All outputs 0, including o_s_tready, o_grant and o_m_*.
- States: IDLE, XFER, ABORT, DRAIN, IFG.
- IDLE:
  - If any i_s_tvalid is high, select the first requester at or after the RR pointer (wrapping at P_NUM_REQ-1 -> 0).
  - Register it in o_grant and go to XFER next cycle.
  - Grant latency is 1 cycle; no data passes in IDLE.
- XFER (combinational pass-through of the granted requester):
  - o_m_tdata/tvalid/tlast = granted slice; o_s_tready[g] = i_m_tready; all other tready = 0; o_m_tuser = 0.
  - On a beat with tvalid & tready & tlast: RR pointer = g+1 (mod P_NUM_REQ), o_grant clears, go to IFG.
  - A one-byte frame (tlast on the first beat) is legal.
- Stall counter:
  - Runs only in XFER.
  - Increments on cycles where the granted tvalid = 0.
  - Clears on every accepted beat.
  - MAC backpressure (tready = 0 with tvalid = 1) does not count.
  - Reaching P_STALL_TIMEOUT moves the block to ABORT.
- ABORT:
  - Drive o_m_tvalid = 1, tlast = 1, tuser = 1, tdata = 0; all o_s_tready = 0.
  - Hold until i_m_tready; then pulse o_timeout and go to DRAIN.
- DRAIN:
  - o_s_tready[g] = 1; MAC outputs = 0.
  - Discard beats until the granted tlast is accepted, then advance the RR pointer and go to IFG.
  - No timeout applies in DRAIN.
- IFG:
  - Counter runs P_IFG_CYCLES cycles; all tready = 0; outputs 0; then IDLE.
  - Requests asserted during IFG wait; they are arbitrated in IDLE on the first IDLE cycle.
- Simultaneous requests: strict round-robin, so every requester is served once per round.
- o_grant must stay stable for the whole frame.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0; the partial frame is not terminated (the MAC drops frames missing tlast on its own reset).
- Counter widths: $clog2(max(P_IFG_CYCLES, P_STALL_TIMEOUT)+1).

Optional Feature:
Macro ETH_TX_ARBITER_STATS_EN.
- Defined: adds ports o_frame_count (P_NUM_REQ*16, out) and o_abort_count (16, out).
  - o_frame_count[k] increments on each completed frame (tlast accepted in XFER) from requester k.
  - o_abort_count increments on each o_timeout pulse.
  - Both are saturating at 16'hFFFF and cleared by reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package eth_tx_arb_pkg holds:
  - the state enum (IDLE, XFER, ABORT, DRAIN, IFG);
  - lp_STAT_WIDTH = 16;
  - the function computing counter width.
- Sub-module eth_rr_arbiter: combinational round-robin priority picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, grant index, any-request flag.
  - Reused by future RX demux work.

Test Plan:
- Single frame: requester 0 sends a 42-byte ARP reply with MAC always ready.
  - Exactly 42 beats out, tlast on beat 42, tuser = 0.
  - First beat 1 cycle after grant; o_busy falls 12 cycles after tlast.
- Contention: requesters 0 and 1 both raise tvalid in the same cycle, 60-byte frames each.
  - Output order 0 then 1, at least 12 idle cycles between them, next round starts with 0.
- Backpressure: i_m_tready toggled 1/0 every cycle during a 74-byte ICMP reply.
  - All 74 bytes delivered in order; no timeout even though the transfer takes 148 cycles.
- Stall abort: requester 1 sends 10 bytes, then tvalid = 0 for 1024 cycles.
  - One extra beat with tlast = 1, tuser = 1 and data 0; o_timeout pulses once.
  - The remaining 20 bytes are sunk; requester 0 is granted after the IFG.
- Reset mid-frame: assert i_reset_n = 0 at byte 30 of 60.
  - All outputs 0 within the same cycle; after release, a new request from requester 1 is granted first because the pointer is 0 and requester 0 is idle.
- With ETH_TX_ARBITER_STATS_EN: 3 frames from requester 0, 2 from requester 1 and one abort give counts 3 and 2, and o_abort_count = 1.
